// File: rtl/quad_paddle_decoder.sv
// quad_paddle_decoder
//   Input conditioning for the pong paddle. The raw rotary-encoder pins are
//   synchronised and glitch-filtered per channel, then quadrature decoded.
//   The decode drives a saturating paddle position register and reports
//   illegal transitions (both filtered channels changing on the same cycle).
//
// Ports
//   clk25      in   1  pixel clock, all logic on posedge
//   rst        in   1  asynchronous active-high reset
//   rota       in   1  encoder channel A (asynchronous)
//   rotb       in   1  encoder channel B (asynchronous)
//   recentre   in   1  synchronous; forces position to RESET_POS
//   paddle_pos out  9  registered paddle position
//   step_pulse out  1  one-cycle pulse per legal transition
//   step_dir   out  1  direction of last legal transition (1 = increment)
//   quad_err   out  1  one-cycle pulse per illegal transition
//   err_count  out  8  saturating count of illegal transitions
module quad_paddle_decoder #(
  parameter int FILTER_LEN = 16,
  parameter int STEP       = 4,
  parameter int POS_MIN    = 0,
  parameter int POS_MAX    = 508,
  parameter int RESET_POS  = 256
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       rota,
  input  logic       rotb,
  input  logic       recentre,
  output logic [8:0] paddle_pos,
  output logic       step_pulse,
  output logic       step_dir,
  output logic       quad_err,
  output logic [7:0] err_count
);

  localparam logic [7:0] FILT_W        = 8'(FILTER_LEN);
  localparam logic [9:0] STEP_W        = 10'(STEP);
  localparam logic [8:0] STEP9         = 9'(STEP);
  localparam logic [9:0] POS_MAX_W     = 10'(POS_MAX);
  localparam logic [8:0] POS_MAX9      = 9'(POS_MAX);
  localparam logic [8:0] POS_MIN9      = 9'(POS_MIN);
  localparam logic [9:0] MIN_PLUS_STEP = 10'(POS_MIN + STEP);
  localparam logic [8:0] RESET_POS9    = 9'(RESET_POS);

  // Synchroniser flops
  logic a_meta_q, a_sync_q, b_meta_q, b_sync_q;

  // Filter state
  logic       a_f_q, a_f_d, b_f_q, b_f_d;
  logic [7:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [7:0] cnt_a_inc_s, cnt_b_inc_s;

  // Decode state and outputs
  logic [1:0] prev_q;
  logic [1:0] cur_s;
  logic       inc_s, dec_s, err_s;
  logic [8:0] pos_q, pos_d;
  logic [9:0] pos_up_s;
  logic [8:0] pos_dn_s;
  logic       step_pulse_q, step_dir_q, step_dir_d, quad_err_q;
  logic [7:0] err_count_q, err_count_d;

  // Two-flop synchroniser per channel
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      a_meta_q <= 1'b0;
      a_sync_q <= 1'b0;
      b_meta_q <= 1'b0;
      b_sync_q <= 1'b0;
    end else begin
      a_meta_q <= rota;
      a_sync_q <= a_meta_q;
      b_meta_q <= rotb;
      b_sync_q <= b_meta_q;
    end
  end

  assign cnt_a_inc_s = cnt_a_q + 8'd1;
  assign cnt_b_inc_s = cnt_b_q + 8'd1;

  // Glitch filters: a channel's filtered value only follows the synced value
  // after it has disagreed for FILTER_LEN consecutive cycles.
  always_comb begin
    a_f_d   = a_f_q;
    cnt_a_d = 8'd0;
    if (a_sync_q == a_f_q) begin
      cnt_a_d = 8'd0;
    end else if (cnt_a_inc_s == FILT_W) begin
      a_f_d   = a_sync_q;
      cnt_a_d = 8'd0;
    end else begin
      cnt_a_d = cnt_a_inc_s;
    end

    b_f_d   = b_f_q;
    cnt_b_d = 8'd0;
    if (b_sync_q == b_f_q) begin
      cnt_b_d = 8'd0;
    end else if (cnt_b_inc_s == FILT_W) begin
      b_f_d   = b_sync_q;
      cnt_b_d = 8'd0;
    end else begin
      cnt_b_d = cnt_b_inc_s;
    end
  end

  // Filter registers
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      a_f_q   <= 1'b0;
      b_f_q   <= 1'b0;
      cnt_a_q <= 8'd0;
      cnt_b_q <= 8'd0;
    end else begin
      a_f_q   <= a_f_d;
      b_f_q   <= b_f_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end

  assign cur_s = {a_f_q, b_f_q};

  // Quadrature decode on {prev, cur}; increment order is 00->01->11->10->00.
  // A two-bit change is possible because the channel filters are independent.
  always_comb begin
    inc_s = 1'b0;
    dec_s = 1'b0;
    err_s = 1'b0;
    case ({prev_q, cur_s})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: inc_s = 1'b1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: dec_s = 1'b1;
      4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: err_s = 1'b1;
      default: begin
        inc_s = 1'b0;
        dec_s = 1'b0;
        err_s = 1'b0;
      end
    endcase
  end

  // One extra bit on the increment keeps the saturation compare free of wrap
  assign pos_up_s = {1'b0, pos_q} + STEP_W;
  assign pos_dn_s = pos_q - STEP9;

  // Next position, direction and error count. recentre wins over a step for
  // the position only; the step pulse and direction still follow the decode.
  always_comb begin
    pos_d       = pos_q;
    step_dir_d  = step_dir_q;
    err_count_d = err_count_q;

    if (recentre) begin
      pos_d = RESET_POS9;
    end else if (inc_s) begin
      if (pos_up_s > POS_MAX_W) begin
        pos_d = POS_MAX9;
      end else begin
        pos_d = pos_up_s[8:0];
      end
    end else if (dec_s) begin
      if ({1'b0, pos_q} < MIN_PLUS_STEP) begin
        pos_d = POS_MIN9;
      end else begin
        pos_d = pos_dn_s;
      end
    end else begin
      pos_d = pos_q;
    end

    if (inc_s) begin
      step_dir_d = 1'b1;
    end else if (dec_s) begin
      step_dir_d = 1'b0;
    end else begin
      step_dir_d = step_dir_q;
    end

    if (err_s && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // Decode history and registered outputs
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      prev_q       <= 2'b00;
      pos_q        <= RESET_POS9;
      step_pulse_q <= 1'b0;
      step_dir_q   <= 1'b0;
      quad_err_q   <= 1'b0;
      err_count_q  <= 8'd0;
    end else begin
      prev_q       <= cur_s;
      pos_q        <= pos_d;
      step_pulse_q <= inc_s | dec_s;
      step_dir_q   <= step_dir_d;
      quad_err_q   <= err_s;
      err_count_q  <= err_count_d;
    end
  end

  assign paddle_pos = pos_q;
  assign step_pulse = step_pulse_q;
  assign step_dir   = step_dir_q;
  assign quad_err   = quad_err_q;
  assign err_count  = err_count_q;

endmodule
